// File: rtl/gcm_pkg.sv
// ---------------------------------------------------------------------------
// gcm_pkg
// Shared constants and types for the GCM input packer slice.
//   WORD_W          - width of one input word (32)
//   BLOCK_W         - width of one assembled GCM block (128)
//   WORDS_PER_BLOCK - words shifted in per block (4)
//   CNT_W           - width of the word counter (2, wraps 3->0)
//   WAIT_W          - width of the tag-wait counter (covers TAG_TIMEOUT up to 65535)
//   state_t         - packer FSM states
// ---------------------------------------------------------------------------
package gcm_pkg;

    localparam int WORD_W          = 32;
    localparam int BLOCK_W         = 128;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int CNT_W           = 2;
    localparam int WAIT_W          = 16;

    typedef enum logic [1:0] {
        ST_FILL     = 2'd0,
        ST_LAUNCH   = 2'd1,
        ST_WAIT_TAG = 2'd2
    } state_t;

endpackage

// File: rtl/gcm_input_packer_if.sv
// ---------------------------------------------------------------------------
// gcm_input_packer_if
// Bundles the word-stream handshake, the sideband input, the downstream block
// outputs and the tag/status flags of the packer.
//   master modport: producer/upstream side (drives data, valid, bypass_in,
//                   tag_ready; observes ready and the packer outputs)
//   slave modport : packer side (the mirror image)
// ---------------------------------------------------------------------------
interface gcm_input_packer_if;
    import gcm_pkg::*;

    logic [WORD_W-1:0]  data;
    logic               valid;
    logic               ready;
    logic [BLOCK_W-1:0] bypass_in;
    logic               new_blk;
    logic [BLOCK_W-1:0] plain_text;
    logic [BLOCK_W-1:0] bypass_out;
    logic               tag_ready;
    logic               busy;
    logic               timeout;

    modport master (
        output data, valid, bypass_in, tag_ready,
        input  ready, new_blk, plain_text, bypass_out, busy, timeout
    );

    modport slave (
        input  data, valid, bypass_in, tag_ready,
        output ready, new_blk, plain_text, bypass_out, busy, timeout
    );

endinterface

// File: rtl/gcm_word_shifter.sv
// ---------------------------------------------------------------------------
// gcm_word_shifter
// 32-to-128 shift register with a wrapping word counter. The first word of a
// block ends up in the most significant 32 bits (GCM bit order [0:31]).
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   i_shift_en      - accept i_word this cycle
//   i_word          - incoming word
//   o_block         - current assembly register contents
//   o_next_block    - assembly value after shifting in i_word (used to copy
//                     out a complete block on the same edge as word 3)
//   o_count         - number of words already held in the current block
//   o_first         - i_word is word 0 of a block and is being accepted
//   o_last          - i_word is word 3 of a block and is being accepted
// ---------------------------------------------------------------------------
module gcm_word_shifter
    import gcm_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_shift_en,
    input  logic [WORD_W-1:0]  i_word,
    output logic [BLOCK_W-1:0] o_block,
    output logic [BLOCK_W-1:0] o_next_block,
    output logic [CNT_W-1:0]   o_count,
    output logic               o_first,
    output logic               o_last
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS_PER_BLOCK - 1);

    logic [BLOCK_W-1:0] r_block;
    logic [CNT_W-1:0]   r_count;
    logic [BLOCK_W-1:0] w_shifted;

    assign w_shifted = {r_block[BLOCK_W-WORD_W-1:0], i_word};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_block <= '0;
            r_count <= '0;
        end else if (i_shift_en) begin
            r_block <= w_shifted;
            // Natural 2-bit wrap takes the counter from 3 back to 0.
            r_count <= r_count + 1'b1;
        end
    end

    assign o_block      = r_block;
    assign o_next_block = w_shifted;
    assign o_count      = r_count;
    assign o_first      = i_shift_en && (r_count == '0);
    assign o_last       = i_shift_en && (r_count == LAST_IDX);

endmodule

// File: rtl/gcm_input_packer.sv
// ---------------------------------------------------------------------------
// gcm_input_packer
// Packs four 32-bit plaintext words into a 128-bit block, launches a
// downstream GCM instance with a one-cycle o_new pulse, then waits for the
// downstream tag-ready flag (or a timeout) before accepting the next block.
// Parameters:
//   TAG_TIMEOUT     - max cycles spent in WAIT_TAG before abort (2..65535)
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   i_data, i_valid - word stream input; o_ready is the accept handshake
//   i_bypass_text   - sideband, captured with word 0 of each block
//   o_new           - one-cycle start pulse to the downstream instance
//   o_plain_text    - assembled block, stable from LAUNCH to next LAUNCH
//   o_bypass_text   - captured sideband, stable with o_plain_text
//   i_tag_ready     - downstream done flag, only honoured in WAIT_TAG
//   o_busy          - high in LAUNCH and WAIT_TAG
//   o_timeout       - one-cycle pulse when WAIT_TAG is aborted
// ---------------------------------------------------------------------------
module gcm_input_packer
    import gcm_pkg::*;
#(
    parameter int TAG_TIMEOUT = 256
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [WORD_W-1:0]  i_data,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [BLOCK_W-1:0] i_bypass_text,
    output logic               o_new,
    output logic [BLOCK_W-1:0] o_plain_text,
    output logic [BLOCK_W-1:0] o_bypass_text,
    input  logic               i_tag_ready,
    output logic               o_busy,
    output logic               o_timeout
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TAG_TIMEOUT - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [WAIT_W-1:0]  r_wait;
    logic [BLOCK_W-1:0] r_side;
    logic [BLOCK_W-1:0] r_plain;
    logic [BLOCK_W-1:0] r_bypass;
    logic               r_timeout;
    logic               w_timeout_hit;

    logic               w_xfer;
    logic [BLOCK_W-1:0] w_block;
    logic [BLOCK_W-1:0] w_next_block;
    logic [CNT_W-1:0]   w_count;
    logic               w_first;
    logic               w_last;

    // o_ready comes straight from the state register, so it is 1 while rst
    // is held (reset forces FILL asynchronously).
    assign o_ready = (r_state == ST_FILL);
    assign w_xfer  = i_valid && o_ready;

    gcm_word_shifter u_shifter (
        .clk          (clk),
        .rst          (rst),
        .i_shift_en   (w_xfer),
        .i_word       (i_data),
        .o_block      (w_block),
        .o_next_block (w_next_block),
        .o_count      (w_count),
        .o_first      (w_first),
        .o_last       (w_last)
    );

    // Sideband is sampled on word 0 only; later words leave it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_side <= '0;
        end else if (w_first) begin
            r_side <= i_bypass_text;
        end
    end

    // Outputs load on the word-3 edge, so they are valid in the LAUNCH cycle
    // and hold until the next block completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_plain  <= '0;
            r_bypass <= '0;
        end else if (w_last) begin
            r_plain  <= w_next_block;
            r_bypass <= r_side;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    // i_tag_ready is only looked at in WAIT_TAG, and it wins over the
    // timeout when both land in the same cycle.
    always_comb begin
        w_next_state  = r_state;
        w_timeout_hit = 1'b0;
        case (r_state)
            ST_FILL: begin
                if (w_last) begin
                    w_next_state = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                w_next_state = ST_WAIT_TAG;
            end
            ST_WAIT_TAG: begin
                if (i_tag_ready) begin
                    w_next_state = ST_FILL;
                end else if (r_wait == WAIT_LAST) begin
                    w_next_state  = ST_FILL;
                    w_timeout_hit = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_FILL;
            end
        endcase
    end

    // Cleared in LAUNCH so WAIT_TAG always starts from 0; counts 0..TAG_TIMEOUT-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait <= '0;
        end else if (r_state == ST_LAUNCH) begin
            r_wait <= '0;
        end else if (r_state == ST_WAIT_TAG) begin
            r_wait <= r_wait + 1'b1;
        end
    end

    // Registered so the pulse coincides with the first FILL cycle after abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout_hit;
        end
    end

    assign o_new         = (r_state == ST_LAUNCH);
    assign o_busy        = (r_state == ST_LAUNCH) || (r_state == ST_WAIT_TAG);
    assign o_timeout     = r_timeout;
    assign o_plain_text  = r_plain;
    assign o_bypass_text = r_bypass;

endmodule

// File: tb/tb_gcm_input_packer.sv
module tb_gcm_input_packer;
    import gcm_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gcm_input_packer_if bus ();

    gcm_input_packer #(.TAG_TIMEOUT(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_data        (bus.data),
        .i_valid       (bus.valid),
        .o_ready       (bus.ready),
        .i_bypass_text (bus.bypass_in),
        .o_new         (bus.new_blk),
        .o_plain_text  (bus.plain_text),
        .o_bypass_text (bus.bypass_out),
        .i_tag_ready   (bus.tag_ready),
        .o_busy        (bus.busy),
        .o_timeout     (bus.timeout)
    );

    int total   = 0;
    int bad     = 0;
    int new_cnt = 0;
    int n0      = 0;

    localparam logic [127:0] BP_X = 128'hDEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD;

    // Count o_new pulses away from the active edge.
    always @(negedge clk) begin
        if (bus.new_blk === 1'b1) new_cnt++;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] w, input logic [127:0] bp);
        bus.data      = w;
        bus.bypass_in = bp;
        bus.valid     = 1'b1;
        chk("ready_fill", 128'(bus.ready), 128'(1));
        tick();
        bus.valid = 1'b0;
    endtask

    task automatic put_block(input logic [127:0] blk, input logic [127:0] bp, input int gap);
        logic [127:0] b;
        b = blk;
        for (int i = 0; i < 4; i++) begin
            repeat (gap) tick();
            put(b[127-32*i -: 32], (i == 0) ? bp : BP_X);
        end
    endtask

    task automatic launch_chk(input string tag, input logic [127:0] exp_plain, input logic [127:0] exp_bp);
        chk({tag, "_new"},    128'(bus.new_blk), 128'(1));
        chk({tag, "_plain"},  bus.plain_text, exp_plain);
        chk({tag, "_bypass"}, bus.bypass_out, exp_bp);
        chk({tag, "_busy"},   128'(bus.busy), 128'(1));
        chk({tag, "_ready"},  128'(bus.ready), 128'(0));
    endtask

    task automatic finish_tag();
        bus.tag_ready = 1'b1;
        tick();
        bus.tag_ready = 1'b0;
        chk("tag_ready_back", 128'(bus.ready), 128'(1));
        chk("tag_no_timeout", 128'(bus.timeout), 128'(0));
    endtask

    initial begin
        bus.valid     = 1'b0;
        bus.data      = '0;
        bus.bypass_in = '0;
        bus.tag_ready = 1'b0;
        #1;
        // reset state
        chk("rst_ready",   128'(bus.ready), 128'(1));
        chk("rst_plain",   bus.plain_text, 128'(0));
        chk("rst_bypass",  bus.bypass_out, 128'(0));
        chk("rst_new",     128'(bus.new_blk), 128'(0));
        chk("rst_busy",    128'(bus.busy), 128'(0));
        chk("rst_timeout", 128'(bus.timeout), 128'(0));
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // basic back-to-back block
        put_block(128'h00112233_44556677_8899AABB_CCDDEEFF, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666, 0);
        launch_chk("basic", 128'h00112233_44556677_8899AABB_CCDDEEFF, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666);
        tick();
        chk("basic_new_drop",  128'(bus.new_blk), 128'(0));
        chk("basic_wait_busy", 128'(bus.busy), 128'(1));
        chk("basic_hold",      bus.plain_text, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        finish_tag();
        chk("basic_new_count", 128'(new_cnt), 128'(1));

        // gapped input
        n0 = new_cnt;
        put_block(128'h00112233_44556677_8899AABB_CCDDEEFF, 128'hB0B0_B0B0_B0B0_B0B0_B0B0_B0B0_B0B0_B0B0, 5);
        launch_chk("gap", 128'h00112233_44556677_8899AABB_CCDDEEFF, 128'hB0B0_B0B0_B0B0_B0B0_B0B0_B0B0_B0B0_B0B0);
        tick();
        finish_tag();
        repeat (3) tick();
        chk("gap_new_count", 128'(new_cnt - n0), 128'(1));

        // back-pressure during WAIT_TAG
        put_block(128'h01010101_02020202_03030303_04040404, 128'hC0C0, 0);
        launch_chk("bp_c", 128'h01010101_02020202_03030303_04040404, 128'hC0C0);
        tick();
        bus.data      = 32'h1111_0000;
        bus.bypass_in = 128'hD00D_F00D;
        bus.valid     = 1'b1;
        chk("bp_ready0_a", 128'(bus.ready), 128'(0));
        tick();
        chk("bp_ready0_b", 128'(bus.ready), 128'(0));
        bus.tag_ready = 1'b1;
        tick();
        bus.tag_ready = 1'b0;
        chk("bp_ready1", 128'(bus.ready), 128'(1));
        tick();
        bus.valid = 1'b0;
        put(32'h2222_0000, BP_X);
        put(32'h3333_0000, BP_X);
        put(32'h4444_0000, BP_X);
        launch_chk("bp_d", 128'h11110000_22220000_33330000_44440000, 128'hD00D_F00D);
        tick();
        finish_tag();

        // timeout with TAG_TIMEOUT=8
        put_block(128'hE0E0E0E0_E1E1E1E1_E2E2E2E2_E3E3E3E3, 128'hE, 0);
        launch_chk("to", 128'hE0E0E0E0_E1E1E1E1_E2E2E2E2_E3E3E3E3, 128'hE);
        tick();
        chk("to_wait0", 128'(bus.timeout), 128'(0));
        for (int k = 1; k < 8; k++) begin
            tick();
            chk("to_early", 128'(bus.timeout), 128'(0));
            chk("to_busy",  128'(bus.busy), 128'(1));
        end
        tick();
        chk("to_pulse", 128'(bus.timeout), 128'(1));
        chk("to_ready", 128'(bus.ready), 128'(1));
        chk("to_idle",  128'(bus.busy), 128'(0));
        tick();
        chk("to_one_cycle", 128'(bus.timeout), 128'(0));

        // tag_ready in the final timeout cycle
        put_block(128'hF0F0F0F0_F1F1F1F1_F2F2F2F2_F3F3F3F3, 128'hF, 0);
        launch_chk("sim", 128'hF0F0F0F0_F1F1F1F1_F2F2F2F2_F3F3F3F3, 128'hF);
        tick();
        for (int k = 1; k < 8; k++) begin
            tick();
        end
        bus.tag_ready = 1'b1;
        tick();
        bus.tag_ready = 1'b0;
        chk("sim_no_timeout", 128'(bus.timeout), 128'(0));
        chk("sim_ready",      128'(bus.ready), 128'(1));
        tick();
        chk("sim_no_late_to", 128'(bus.timeout), 128'(0));

        // reset mid-fill
        put(32'h9999_9999, 128'h99);
        put(32'h8888_8888, BP_X);
        #2 rst = 1'b1;
        #1;
        chk("rmf_ready",  128'(bus.ready), 128'(1));
        chk("rmf_plain",  bus.plain_text, 128'(0));
        chk("rmf_bypass", bus.bypass_out, 128'(0));
        tick();
        rst = 1'b0;
        n0 = new_cnt;
        put_block(128'h10000001_20000002_30000003_40000004, 128'h1234, 0);
        launch_chk("rmf", 128'h10000001_20000002_30000003_40000004, 128'h1234);
        tick();
        finish_tag();
        chk("rmf_new_count", 128'(new_cnt - n0), 128'(1));

        // reset during LAUNCH
        put_block(128'h55555555_66666666_77777777_88888888, 128'h5678, 0);
        n0 = new_cnt;
        chk("rl_launch", 128'(bus.new_blk), 128'(1));
        #2 rst = 1'b1;
        #1;
        chk("rl_new_kill", 128'(bus.new_blk), 128'(0));
        chk("rl_busy",     128'(bus.busy), 128'(0));
        chk("rl_ready",    128'(bus.ready), 128'(1));
        tick();
        rst = 1'b0;
        tick();
        chk("rl_no_new", 128'(new_cnt - n0), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
